krnl_aurora_csr_s_axi: RTL
==========================

# krnl_aurora_csr_s_axi

Parametrised AXI4-Lite control/status slave for the Aurora kernel, the successor to the single-status read-only control block. It serves NUM_CH Aurora channels, each with a live status word, a sticky change-capture register (write-1-to-clear) and a read/write control word. It also provides a global control/mask register and a level interrupt. It sits between the host AXI4-Lite control port and the per-channel Aurora cores and status logic.

## Interface
- ADDR_W, 12, AXI address width (byte address)
- NUM_CH, 2, Aurora channel count, 1..8
- STATUS_W, 13, per-channel status width, 1..32
- CTRL_W, 8, per-channel control width, 1..32
- VERSION, 32'h0002_0000, value returned at 0x000

- ACLK  in  1  kernel clock
- ARESETn  in  1  reset; one clock; reset is synchronous and active-low
- AWADDR  in  ADDR_W  write address
- AWVALID / AWREADY  in / out  1  write address handshake
- WDATA  in  32  write data
- WSTRB  in  4  byte enables
- WVALID / WREADY  in / out  1  write data handshake
- BRESP  out  2  always 2'b00
- BVALID / BREADY  out / in  1  write response handshake
- ARADDR  in  ADDR_W  read address
- ARVALID / ARREADY  in / out  1  read address handshake
- RDATA  out  32  read data
- RRESP  out  2  always 2'b00
- RVALID / RREADY  out / in  1  read data handshake
- status_in  in  NUM_CH*STATUS_W  channel c occupies bits [c*STATUS_W +: STATUS_W]; already synchronous to ACLK
- ctrl_out  out  NUM_CH*CTRL_W  per-channel control, same packing
- irq  out  1  level interrupt

## Operation
- Register map. Only AWADDR/ARADDR[ADDR_W-1:2] are decoded.
  - 0x000 VERSION (RO)
  - 0x004 GCTRL (RW): bit0 irq_en; other bits read 0
  - 0x008 IRQ_MASK (RW): bit c enables channel c; bits ≥ NUM_CH read 0
  - Per channel, at 0x010 + 0x10*c:
    - +0x0 STATUS (RO): live status_in slice, zero-extended
    - +0x4 STICKY (W1C): bits set on any change of status
    - +0x8 CTRL (RW): drives ctrl_out slice
    - +0xC reserved
- Unmapped reads return 0. Unmapped, RO or reserved writes are ignored. Every access completes with OKAY.
- WSTRB applies byte-wise to RW registers and to W1C clears. A byte with strobe 0 is unchanged.
- Sticky logic:
  - status_q is a registered copy of status_in.
  - Each cycle: sticky_next = (sticky & ~clr) | (status_in ^ status_q).
  - When a set and a clear hit the same bit in the same cycle, the set wins.
- Interrupt: irq is registered, irq = irq_en & |(mask[c] & |sticky[c]) over all c.
- Write FSM states WRIDLE → WRDATA → WRRESP:
  - WRIDLE: AWREADY=1. AW handshake latches the address and moves to WRDATA.
  - WRDATA: WREADY=1. W handshake performs the register update and moves to WRRESP.
  - WRRESP: BVALID=1. Returns to WRIDLE on BREADY.
- Read FSM states RDIDLE → RDDATA:
  - RDIDLE: ARREADY=1. AR handshake latches RDATA from the register values of that cycle and moves to RDDATA.
  - RDDATA: RVALID=1. Returns to RDIDLE on RREADY.
- Read and write FSMs are independent. A read of STICKY in the same cycle as a W1C write to it returns the pre-clear value.

## Timing
- While ARESETn=0, and in the first cycle after release, all of the following are 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, ctrl_out, GCTRL, IRQ_MASK, sticky, status_q, irq. status_q loads status_in from the first post-reset cycle onward, so no sticky bit is set by the reset value.
- Both FSMs enter their IDLE state on the cycle after ARESETn rises.
- Reset mid-transaction aborts the transaction: no BVALID or RVALID is produced and no register is updated.
- Read latency: AR handshake in cycle N → RVALID in cycle N+1. RDATA is held stable until the RREADY handshake.
- Write latency:
  - AW handshake in cycle N → WREADY in cycle N+1.
  - W handshake in cycle M → register, ctrl_out and BVALID all change in cycle M+1.
- Maximum throughput: read, one per 2 cycles; write, one per 3 cycles.
- Sticky latency: status change visible in status_in in cycle N → sticky bit set in cycle N+1 → irq high in cycle N+2, if enabled.
- irq falls 2 cycles after the W handshake that clears the last enabled sticky bit.

## Test plan
- Reset then read 0x000, 0x004, 0x014 → 32'h0002_0000, 0, 0. irq=0; ctrl_out=0.
- Write 0x018 = 32'hFFFF_FFA5 with WSTRB=4'b0001 and CTRL_W=8 → ctrl_out[7:0]=8'hA5 one cycle after the W handshake. Read 0x018 returns 32'h0000_00A5. Channel 1 ctrl_out is unchanged.
- Toggle channel 0 status bit 3 for one cycle; GCTRL=1; IRQ_MASK=1 → STICKY (0x014) reads 32'h8 and irq=1. Write 32'h8 to 0x014 → irq=0 two cycles after the W handshake; re-read returns 0.
- Toggle channel 0 status bit 3 in the same cycle as a W1C write of bit 3 → bit remains set and irq stays high.
- Read 0x0FC (unmapped) → RDATA=0, RRESP=00. Write 0x010 (RO) → BRESP=00, STATUS read is unaffected.
- Hold RREADY/BREADY low for 5 cycles → RVALID/BVALID and RDATA stay stable. Assert ARESETn=0 during WRDATA → no BVALID; ctrl_out=0 after reset.

Source files
------------

// File: rtl/krnl_aurora_csr_s_axi.sv
`default_nettype none
// ============================================================================
// Module   : krnl_aurora_csr_s_axi
// Purpose  : AXI4-Lite control/status slave for the Aurora kernel. Serves
//            NUM_CH channels, each with a live status word, a sticky
//            change-capture register (write-1-to-clear) and a control word,
//            plus a global control register, an interrupt mask register and a
//            registered level interrupt.
// Ports    : ACLK/ARESETn         clock, synchronous active-low reset
//            AW*/W*/B*            AXI4-Lite write channels
//            AR*/R*               AXI4-Lite read channels
//            status_in            packed per-channel status (ACLK domain)
//            ctrl_out             packed per-channel control
//            irq                  level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module krnl_aurora_csr_s_axi #(
    parameter int          ADDR_W   = 12,
    parameter int          NUM_CH   = 2,
    parameter int          STATUS_W = 13,
    parameter int          CTRL_W   = 8,
    parameter logic [31:0] VERSION  = 32'h0002_0000
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ADDR_W-1:0]            AWADDR,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [31:0]                  WDATA,
    input  logic [3:0]                   WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [31:0]                  RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic [NUM_CH*STATUS_W-1:0]   status_in,
    output logic [NUM_CH*CTRL_W-1:0]     ctrl_out,
    output logic                         irq
);

    // The RESET states hold all ready/valid outputs low for the first cycle
    // after reset release; both FSMs reach IDLE one cycle later.
    typedef enum logic [1:0] {
        WRRESET = 2'd0,
        WRIDLE  = 2'd1,
        WRDATA  = 2'd2,
        WRRESP  = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        RDRESET = 2'd0,
        RDIDLE  = 2'd1,
        RDDATA  = 2'd2
    } rd_state_t;

    wr_state_t                  r_wr_state, w_wr_next;
    rd_state_t                  r_rd_state, w_rd_next;
    logic [ADDR_W-3:0]          r_waddr;
    logic [31:0]                r_rdata, w_rdata;
    logic                       r_irq_en, w_irq_en_next;
    logic [NUM_CH-1:0]          r_mask, w_mask_next;
    logic [NUM_CH*CTRL_W-1:0]   r_ctrl, w_ctrl_next;
    logic [NUM_CH*STATUS_W-1:0] r_status_q, r_sticky, w_clr;
    logic                       r_init;
    logic                       r_irq;
    logic [NUM_CH-1:0]          w_ch_pending;
    logic [31:0]                w_wmask, w_wword, w_rword;
    logic                       w_aw_fire, w_w_fire, w_ar_fire;
    logic                       w_unused;

    assign AWREADY  = (r_wr_state == WRIDLE);
    assign WREADY   = (r_wr_state == WRDATA);
    assign BVALID   = (r_wr_state == WRRESP);
    assign BRESP    = 2'b00;
    assign ARREADY  = (r_rd_state == RDIDLE);
    assign RVALID   = (r_rd_state == RDDATA);
    assign RRESP    = 2'b00;
    assign RDATA    = r_rdata;
    assign ctrl_out = r_ctrl;
    assign irq      = r_irq;

    assign w_aw_fire = AWREADY & AWVALID;
    assign w_w_fire  = WREADY & WVALID;
    assign w_ar_fire = ARREADY & ARVALID;

    assign w_wmask = {{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}};
    assign w_wword = 32'(r_waddr);
    assign w_rword = 32'(ARADDR[ADDR_W-1:2]);

    // Byte lanes and address bits that no register consumes.
    assign w_unused = &{1'b0, AWADDR[1:0], ARADDR[1:0], WDATA, w_wmask};

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_ch_pending[c] = |r_sticky[c*STATUS_W +: STATUS_W];
        end
    endgenerate

    // ---------------------------------------------------------------- FSMs
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wr_state <= WRRESET;
            r_rd_state <= RDRESET;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WRRESET: w_wr_next = WRIDLE;
            WRIDLE:  if (AWVALID) w_wr_next = WRDATA;
            WRDATA:  if (WVALID)  w_wr_next = WRRESP;
            WRRESP:  if (BREADY)  w_wr_next = WRIDLE;
            default: w_wr_next = WRRESET;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RDRESET: w_rd_next = RDIDLE;
            RDIDLE:  if (ARVALID) w_rd_next = RDDATA;
            RDDATA:  if (RREADY)  w_rd_next = RDIDLE;
            default: w_rd_next = RDRESET;
        endcase
    end

    // -------------------------------------------------- write-side decode
    always_comb begin
        w_irq_en_next = r_irq_en;
        w_mask_next   = r_mask;
        w_ctrl_next   = r_ctrl;
        w_clr         = '0;
        if (w_w_fire) begin
            if (w_wword == 32'd1 && WSTRB[0]) begin
                w_irq_en_next = WDATA[0];
            end
            if (w_wword == 32'd2 && WSTRB[0]) begin
                w_mask_next = WDATA[NUM_CH-1:0];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wword == 32'(4 + 4*c + 1)) begin
                    w_clr[c*STATUS_W +: STATUS_W] = WDATA[STATUS_W-1:0] & w_wmask[STATUS_W-1:0];
                end
                if (w_wword == 32'(4 + 4*c + 2)) begin
                    w_ctrl_next[c*CTRL_W +: CTRL_W] =
                        (r_ctrl[c*CTRL_W +: CTRL_W] & ~w_wmask[CTRL_W-1:0]) |
                        (WDATA[CTRL_W-1:0] & w_wmask[CTRL_W-1:0]);
                end
            end
        end
    end

    // --------------------------------------------------- read-side decode
    always_comb begin
        w_rdata = '0;
        case (w_rword)
            32'd0:   w_rdata = VERSION;
            32'd1:   w_rdata = {31'd0, r_irq_en};
            32'd2:   w_rdata = 32'(r_mask);
            default: w_rdata = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_rword == 32'(4 + 4*c))     w_rdata = 32'(status_in[c*STATUS_W +: STATUS_W]);
            if (w_rword == 32'(4 + 4*c + 1)) w_rdata = 32'(r_sticky[c*STATUS_W +: STATUS_W]);
            if (w_rword == 32'(4 + 4*c + 2)) w_rdata = 32'(r_ctrl[c*CTRL_W +: CTRL_W]);
        end
    end

    // ------------------------------------------------------- registers
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_waddr    <= '0;
            r_rdata    <= '0;
            r_irq_en   <= 1'b0;
            r_mask     <= '0;
            r_ctrl     <= '0;
            r_status_q <= '0;
            r_sticky   <= '0;
            r_init     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_init     <= 1'b1;
            r_status_q <= status_in;
            // status_q is still zero in the first post-reset cycle, so
            // change capture waits one cycle to avoid flagging the reset value.
            // Clear is applied before set so a coincident change survives.
            if (r_init) begin
                r_sticky <= (r_sticky & ~w_clr) | (status_in ^ r_status_q);
            end
            r_irq_en <= w_irq_en_next;
            r_mask   <= w_mask_next;
            r_ctrl   <= w_ctrl_next;
            r_irq    <= r_irq_en & |(r_mask & w_ch_pending);
            if (w_aw_fire) begin
                r_waddr <= AWADDR[ADDR_W-1:2];
            end
            if (w_ar_fire) begin
                r_rdata <= w_rdata;
            end
        end
    end

endmodule
`default_nettype wire
